dice_game_ctrl: RTL and testbench

Parametrised two-die craps controller: the next generation of the board-level dice game. It provides free-running dice counters while `roll` is held, latches and displays the dice on release, and runs a come-out/point game FSM that drives win/loss LEDs. It adds a configurable die size, selectable display polarity, a point indicator, a roll counter, restart-without-reset, and an optional point-phase roll limit. It sits directly under the board top, replacing the fixed-function game FSM.

---
 rtl/dice_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dice_game_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dice_game_ctrl.sv
// Two-die craps controller: free-running dice while roll is held, latch/display on release, come-out/point FSM.
// Optional point-phase roll limit enabled by defining DICE_ROLL_LIMIT_EN.
module dice_game_ctrl #(
    parameter int unsigned FACES           = 6,
    parameter int unsigned DISP_ACTIVE_LOW = 1,
    parameter int unsigned MAX_ROLLS       = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       roll,
    output logic [6:0] seg_disp1,
    output logic [6:0] seg_disp2,
    output logic       win_1,
    output logic       loss_1,
    output logic       point_valid,
    output logic [7:0] roll_count
);

    localparam int unsigned DW = 4;
    localparam int unsigned SW = 5;
    localparam int unsigned CW = 8;

    localparam logic [DW-1:0] FACE_MAX   = DW'(FACES);
    localparam logic [SW-1:0] SEVEN      = SW'(FACES + 1);
    localparam logic [SW-1:0] YO         = SW'(2 * FACES - 1);
    localparam logic [SW-1:0] BOX        = SW'(2 * FACES);
    localparam logic [CW-1:0] ROLL_LIMIT = CW'(MAX_ROLLS);
    localparam logic [6:0]    SEG_BLANK  = (DISP_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    localparam logic [1:0] S_COMEOUT = 2'd0;
    localparam logic [1:0] S_POINT   = 2'd1;
    localparam logic [1:0] S_WIN     = 2'd2;
    localparam logic [1:0] S_LOSS    = 2'd3;

    logic [1:0]    state, state_d;
    logic [DW-1:0] d1, d2;
    logic          roll_q;
    logic [SW-1:0] point, point_d;
    logic [CW-1:0] count_d, count_inc;
    logic          win_d, loss_d, pv_d;
    logic          rel_c;
    logic [SW-1:0] sum_c;

`ifndef DICE_ROLL_LIMIT_EN
    logic unused_limit;
    assign unused_limit = ^ROLL_LIMIT;
`endif

    assign rel_c = roll_q && !roll;
    assign sum_c = SW'(d1) + SW'(d2);

    // Hex digit encoding in active-low form, inverted for active-high displays
    function automatic logic [6:0] seg_enc(input logic [DW-1:0] v);
        logic [6:0] code;
        case (v)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b0000011;
            4'hC:    code = 7'b1000110;
            4'hD:    code = 7'b0100001;
            4'hE:    code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return (DISP_ACTIVE_LOW != 0) ? code : ~code;
    endfunction

    // Dice counters: d1 free-runs while roll is high, d2 steps on d1 wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d1     <= DW'(1);
            d2     <= DW'(1);
            roll_q <= 1'b0;
        end else begin
            roll_q <= roll;
            if (roll) begin
                if (d1 == FACE_MAX) begin
                    d1 <= DW'(1);
                    d2 <= (d2 == FACE_MAX) ? DW'(1) : d2 + DW'(1);
                end else begin
                    d1 <= d1 + DW'(1);
                end
            end
        end
    end

    // Display latches load on the release edge only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_disp1 <= SEG_BLANK;
            seg_disp2 <= SEG_BLANK;
        end else if (rel_c) begin
            seg_disp1 <= seg_enc(d1);
            seg_disp2 <= seg_enc(d2);
        end
    end

    // Game state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_COMEOUT;
            point       <= '0;
            roll_count  <= '0;
            win_1       <= 1'b0;
            loss_1      <= 1'b0;
            point_valid <= 1'b0;
        end else begin
            state       <= state_d;
            point       <= point_d;
            roll_count  <= count_d;
            win_1       <= win_d;
            loss_1      <= loss_d;
            point_valid <= pv_d;
        end
    end

    always_comb begin
        state_d   = state;
        point_d   = point;
        count_d   = roll_count;
        win_d     = win_1;
        loss_d    = loss_1;
        pv_d      = point_valid;
        count_inc = (roll_count == 8'hFF) ? roll_count : roll_count + CW'(1);
        case (state)
            S_COMEOUT: begin
                if (rel_c) begin
                    if (sum_c == SEVEN || sum_c == YO) begin
                        state_d = S_WIN;
                        win_d   = 1'b1;
                    end else if (sum_c == SW'(2) || sum_c == SW'(3) || sum_c == BOX) begin
                        state_d = S_LOSS;
                        loss_d  = 1'b1;
                    end else begin
                        state_d = S_POINT;
                        point_d = sum_c;
                        count_d = '0;
                        pv_d    = 1'b1;
                    end
                end
            end
            S_POINT: begin
                // Point match is checked before seven-out so it wins on overlap
                if (rel_c) begin
                    if (sum_c == point) begin
                        state_d = S_WIN;
                        win_d   = 1'b1;
                        pv_d    = 1'b0;
                    end else if (sum_c == SEVEN) begin
                        state_d = S_LOSS;
                        loss_d  = 1'b1;
                        pv_d    = 1'b0;
                    end else begin
                        count_d = count_inc;
`ifdef DICE_ROLL_LIMIT_EN
                        if (count_inc == ROLL_LIMIT) begin
                            state_d = S_LOSS;
                            loss_d  = 1'b1;
                            pv_d    = 1'b0;
                        end
`endif
                    end
                end
            end
            S_WIN, S_LOSS: begin
                // The restarting press is also the new come-out roll
                if (roll) begin
                    state_d = S_COMEOUT;
                    win_d   = 1'b0;
                    loss_d  = 1'b0;
                    pv_d    = 1'b0;
                    count_d = '0;
                end
            end
            default: state_d = S_COMEOUT;
        endcase
    end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Directed self-checking bench for dice_game_ctrl (FACES=6, active-low display, MAX_ROLLS=2).
module tb_dice_game_ctrl;

    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       roll  = 1'b0;
    logic [6:0] seg_disp1, seg_disp2;
    logic       win_1, loss_1, point_valid;
    logic [7:0] roll_count;

    int checks = 0;
    int errors = 0;

    dice_game_ctrl #(
        .FACES          (6),
        .DISP_ACTIVE_LOW(1),
        .MAX_ROLLS      (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .roll       (roll),
        .seg_disp1  (seg_disp1),
        .seg_disp2  (seg_disp2),
        .win_1      (win_1),
        .loss_1     (loss_1),
        .point_valid(point_valid),
        .roll_count (roll_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold roll for n rising edges, release, and return after the release edge
    task automatic do_roll(input int n);
        @(negedge clock);
        roll = 1'b1;
        repeat (n) @(negedge clock);
        roll = 1'b0;
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg1"}, 32'(seg_disp1), 32'(SEG_BLANK));
        check({tag, "_seg2"}, 32'(seg_disp2), 32'(SEG_BLANK));
        check({tag, "_win"},  32'(win_1), 32'd0);
        check({tag, "_loss"}, 32'(loss_1), 32'd0);
        check({tag, "_pv"},   32'(point_valid), 32'd0);
        check({tag, "_cnt"},  32'(roll_count), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;

        // Natural win: (6,1)
        do_roll(5);
        check("nat_seg1", 32'(seg_disp1), 32'(SEG_6));
        check("nat_seg2", 32'(seg_disp2), 32'(SEG_1));
        check("nat_win",  32'(win_1), 32'd1);
        check("nat_loss", 32'(loss_1), 32'd0);

        // Craps on a 1-cycle pulse: (2,1)
        apply_reset();
        do_roll(1);
        check("craps_seg1", 32'(seg_disp1), 32'(SEG_2));
        check("craps_seg2", 32'(seg_disp2), 32'(SEG_1));
        check("craps_loss", 32'(loss_1), 32'd1);
        // Restart press clears LEDs immediately; display holds until release
        @(negedge clock);
        roll = 1'b1;
        @(negedge clock);
        check("restart_loss", 32'(loss_1), 32'd0);
        check("restart_win",  32'(win_1), 32'd0);
        check("hold_seg1",    32'(seg_disp1), 32'(SEG_2));
        repeat (4) @(negedge clock);
        roll = 1'b0;
        @(negedge clock);
        check("craps2_seg1", 32'(seg_disp1), 32'(SEG_1));
        check("craps2_seg2", 32'(seg_disp2), 32'(SEG_2));
        check("craps2_loss", 32'(loss_1), 32'd1);

        // Point 4, then 5, then make the point with (1,3)
        apply_reset();
        do_roll(2);
        check("pt_seg1", 32'(seg_disp1), 32'(SEG_3));
        check("pt_pv",   32'(point_valid), 32'd1);
        check("pt_win",  32'(win_1), 32'd0);
        check("pt_cnt",  32'(roll_count), 32'd0);
        do_roll(6);
        check("pt2_seg2", 32'(seg_disp2), 32'(SEG_2));
        check("pt2_cnt",  32'(roll_count), 32'd1);
        check("pt2_pv",   32'(point_valid), 32'd1);
        do_roll(4);
        check("ptwin_seg1", 32'(seg_disp1), 32'(SEG_1));
        check("ptwin_seg2", 32'(seg_disp2), 32'(SEG_3));
        check("ptwin_win",  32'(win_1), 32'd1);
        check("ptwin_pv",   32'(point_valid), 32'd0);

        // Seven-out
        apply_reset();
        do_roll(2);
        do_roll(3);
        check("7out_loss", 32'(loss_1), 32'd1);
        check("7out_cnt",  32'(roll_count), 32'd0);
        check("7out_pv",   32'(point_valid), 32'd0);

        // Async reset while roll is high mid-point
        apply_reset();
        do_roll(2);
        do_roll(6);
        check("ar_cnt_pre", 32'(roll_count), 32'd1);
        @(negedge clock);
        roll = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        roll = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_roll(5);
        check("ar_win",  32'(win_1), 32'd1);
        check("ar_seg1", 32'(seg_disp1), 32'(SEG_6));

        // Point 4, then sums 5 and 6
        apply_reset();
        do_roll(2);
        do_roll(6);
        do_roll(6);
        check("lim_cnt", 32'(roll_count), 32'd2);
`ifdef DICE_ROLL_LIMIT_EN
        check("lim_loss", 32'(loss_1), 32'd1);
        check("lim_pv",   32'(point_valid), 32'd0);
`else
        check("lim_loss", 32'(loss_1), 32'd0);
        check("lim_pv",   32'(point_valid), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
